// File: rtl/current_trigger_pkg.sv
// Shared types and helpers for the current-trigger comparator sequencer.
//   state_e  : sequencer state encoding
//   *_W_DEF  : default widths of the counters and config fields
//   sat_inc  : saturating increment, used by the width and event counters
package current_trigger_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned FILT_W_DEF = 4;
    localparam int unsigned HOLD_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        QUALIFY = 3'd2,
        ACTIVE  = 3'd3,
        HOLDOFF = 3'd4
    } state_e;

    // Increment val by one and stick at max_val. Callers cast back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/ctrig_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronized output).
module ctrig_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    // First stage may go metastable; second stage gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/current_trigger_ctrl.sv
// Sequencer for the analog current-trigger comparator: synchronizes and
// glitch-filters the comparator output, arms capture, counts qualified
// triggers, measures pulse width and enforces a hold-off dead time.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   ena               tile enable; low parks the sequencer in IDLE, counters hold
//   trig_raw          asynchronous comparator output
//   arm               capture enable level
//   clear             synchronous clear of event_cnt, pulse_width, overflow
//   filt_len          high samples needed to qualify (0 behaves as 1)
//   holdoff_len       dead-time cycles after a pulse ends
//   armed, busy       state decodes (ARMED/QUALIFY, ACTIVE/HOLDOFF)
//   trig_valid        one-cycle pulse per qualified trigger
//   event_cnt         saturating trigger count
//   pulse_width       width of the last completed pulse (saturating)
//   overflow          sticky: a trigger arrived with event_cnt at max
//   timestamp         cycle count at the last trigger (only with
//                     CURRENT_TRIGGER_TIMESTAMP_EN defined)
module current_trigger_ctrl
    import current_trigger_pkg::*;
#(
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned FILT_W = FILT_W_DEF,
    parameter int unsigned HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              trig_raw,
    input  logic              arm,
    input  logic              clear,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [HOLD_W-1:0] holdoff_len,
    output logic              armed,
    output logic              busy,
    output logic              trig_valid,
    output logic [CNT_W-1:0]  event_cnt,
    output logic [CNT_W-1:0]  pulse_width,
    output logic              overflow
`ifdef CURRENT_TRIGGER_TIMESTAMP_EN
    ,
    output logic [2*CNT_W-1:0] timestamp
`endif
);

    localparam int unsigned    QW      = FILT_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              sync_in;

    state_e            state_q,       state_d;
    logic [FILT_W-1:0] qcnt_q,        qcnt_d;
    logic [CNT_W-1:0]  wcnt_q,        wcnt_d;
    logic [HOLD_W-1:0] hcnt_q,        hcnt_d;
    logic              armed_q,       armed_d;
    logic              busy_q,        busy_d;
    logic              trig_valid_q,  trig_valid_d;
    logic [CNT_W-1:0]  event_cnt_q,   event_cnt_d;
    logic [CNT_W-1:0]  pulse_width_q, pulse_width_d;
    logic              overflow_q,    overflow_d;

    logic              fire;
    logic              pw_latch;
    logic [FILT_W-1:0] filt_eff;
    logic [QW-1:0]     qcnt_inc;
    logic [CNT_W-1:0]  wcnt_inc;

    ctrig_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig_raw),
        .q     (sync_in)
    );

    // Next-state, counters and output staging.
    always_comb begin
        state_d       = state_q;
        qcnt_d        = qcnt_q;
        wcnt_d        = wcnt_q;
        hcnt_d        = hcnt_q;
        event_cnt_d   = event_cnt_q;
        pulse_width_d = pulse_width_q;
        overflow_d    = overflow_q;
        trig_valid_d  = 1'b0;
        fire          = 1'b0;
        pw_latch      = 1'b0;

        filt_eff = (filt_len == '0) ? FILT_W'(1) : filt_len;
        qcnt_inc = {1'b0, qcnt_q} + QW'(1);
        wcnt_inc = CNT_W'(sat_inc(32'(wcnt_q), 32'(CNT_MAX)));

        if (!ena) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arm) state_d = ARMED;
                end
                ARMED: begin
                    if (!arm) begin
                        state_d = IDLE;
                    end else if (sync_in) begin
                        qcnt_d = FILT_W'(1);
                        wcnt_d = CNT_W'(1);
                        // A single-sample filter qualifies on the first high sample.
                        if (filt_eff == FILT_W'(1)) begin
                            state_d = ACTIVE;
                            fire    = 1'b1;
                        end else begin
                            state_d = QUALIFY;
                        end
                    end
                end
                QUALIFY: begin
                    if (!arm) begin
                        state_d = IDLE;
                    end else if (!sync_in) begin
                        state_d = ARMED;
                    end else begin
                        qcnt_d = qcnt_inc[FILT_W-1:0];
                        wcnt_d = wcnt_inc;
                        // >= so a live shrink of filt_len still releases the pulse.
                        if (qcnt_inc >= {1'b0, filt_eff}) begin
                            state_d = ACTIVE;
                            fire    = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    // arm is deliberately ignored so the width measurement completes.
                    if (sync_in) begin
                        wcnt_d = wcnt_inc;
                    end else begin
                        pw_latch = 1'b1;
                        hcnt_d   = '0;
                        state_d  = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hcnt_q >= holdoff_len) begin
                        state_d = arm ? ARMED : IDLE;
                    end else begin
                        hcnt_d = hcnt_q + HOLD_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        trig_valid_d = fire;
        if (fire) begin
            if (event_cnt_q == CNT_MAX) overflow_d = 1'b1;
            event_cnt_d = CNT_W'(sat_inc(32'(event_cnt_q), 32'(CNT_MAX)));
        end
        if (pw_latch) pulse_width_d = wcnt_q;

        // clear wins over any same-cycle increment or latch.
        if (clear) begin
            event_cnt_d   = '0;
            pulse_width_d = '0;
            overflow_d    = 1'b0;
        end

        armed_d = (state_d == ARMED)  || (state_d == QUALIFY);
        busy_d  = (state_d == ACTIVE) || (state_d == HOLDOFF);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            qcnt_q        <= '0;
            wcnt_q        <= '0;
            hcnt_q        <= '0;
            armed_q       <= 1'b0;
            busy_q        <= 1'b0;
            trig_valid_q  <= 1'b0;
            event_cnt_q   <= '0;
            pulse_width_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            qcnt_q        <= qcnt_d;
            wcnt_q        <= wcnt_d;
            hcnt_q        <= hcnt_d;
            armed_q       <= armed_d;
            busy_q        <= busy_d;
            trig_valid_q  <= trig_valid_d;
            event_cnt_q   <= event_cnt_d;
            pulse_width_q <= pulse_width_d;
            overflow_q    <= overflow_d;
        end
    end

    assign armed       = armed_q;
    assign busy        = busy_q;
    assign trig_valid  = trig_valid_q;
    assign event_cnt   = event_cnt_q;
    assign pulse_width = pulse_width_q;
    assign overflow    = overflow_q;

`ifdef CURRENT_TRIGGER_TIMESTAMP_EN
    logic [2*CNT_W-1:0] ts_q,    ts_d;
    logic [2*CNT_W-1:0] tstamp_q, tstamp_d;

    // Free-running cycle counter, captured on each qualified trigger; clear leaves it alone.
    always_comb begin
        ts_d     = ts_q + (2*CNT_W)'(1);
        tstamp_d = fire ? ts_q : tstamp_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q     <= '0;
            tstamp_q <= '0;
        end else begin
            ts_q     <= ts_d;
            tstamp_q <= tstamp_d;
        end
    end

    assign timestamp = tstamp_q;
`endif

endmodule

// File: tb/tb_current_trigger_ctrl.sv
// Bench for current_trigger_ctrl: a phase-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_current_trigger_ctrl;

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned FILT_W = 4;
    localparam int unsigned HOLD_W = 8;
    localparam int          CMAX   = 255;

    localparam int PH_IDLE  = 0;
    localparam int PH_WATCH = 1;
    localparam int PH_PULSE = 2;
    localparam int PH_DEAD  = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              ena = 1'b0;
    logic              trig_raw = 1'b0;
    logic              arm = 1'b0;
    logic              clear = 1'b0;
    logic [FILT_W-1:0] filt_len = '0;
    logic [HOLD_W-1:0] holdoff_len = '0;
    logic              armed;
    logic              busy;
    logic              trig_valid;
    logic [CNT_W-1:0]  event_cnt;
    logic [CNT_W-1:0]  pulse_width;
    logic              overflow;
`ifdef CURRENT_TRIGGER_TIMESTAMP_EN
    logic [2*CNT_W-1:0] timestamp;
`endif

    always #5 clk = ~clk;

    current_trigger_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .trig_raw    (trig_raw),
        .arm         (arm),
        .clear       (clear),
        .filt_len    (filt_len),
        .holdoff_len (holdoff_len),
        .armed       (armed),
        .busy        (busy),
        .trig_valid  (trig_valid),
        .event_cnt   (event_cnt),
        .pulse_width (pulse_width),
        .overflow    (overflow)
`ifdef CURRENT_TRIGGER_TIMESTAMP_EN
        ,
        .timestamp   (timestamp)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the delayed comparator level, a run length of
    // consecutive high samples while watching, and the dead-time count.
    int m_s1, m_s2, m_phase, m_run, m_width, m_dead, m_cnt, m_pw;
    bit m_valid, m_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_phase = PH_IDLE; m_run = 0; m_width = 0;
            m_dead = 0; m_cnt = 0; m_pw = 0; m_valid = 0; m_ovf = 0;
        end else begin : model_step
            int n;
            bit fire;
            bit lvl;
            n    = (filt_len == 0) ? 1 : int'(filt_len);
            lvl  = (m_s2 != 0);
            fire = 0;
            if (!ena) begin
                m_phase = PH_IDLE;
                m_run   = 0;
            end else begin
                case (m_phase)
                    PH_IDLE: if (arm) begin m_phase = PH_WATCH; m_run = 0; end
                    PH_WATCH: begin
                        if (!arm) begin
                            m_phase = PH_IDLE; m_run = 0;
                        end else if (!lvl) begin
                            m_run = 0;
                        end else begin
                            m_run++;
                            m_width = m_run;
                            if (m_run >= n) begin m_phase = PH_PULSE; fire = 1; end
                        end
                    end
                    PH_PULSE: begin
                        if (lvl) m_width = (m_width < CMAX) ? m_width + 1 : CMAX;
                        else begin m_pw = m_width; m_dead = 0; m_phase = PH_DEAD; end
                    end
                    default: begin
                        if (m_dead >= int'(holdoff_len)) begin
                            m_phase = arm ? PH_WATCH : PH_IDLE;
                            m_run   = 0;
                        end else m_dead++;
                    end
                endcase
            end
            m_valid = fire;
            if (fire) begin
                if (m_cnt == CMAX) m_ovf = 1; else m_cnt++;
            end
            if (clear) begin m_cnt = 0; m_ovf = 0; m_pw = 0; end
            m_s2 = m_s1;
            m_s1 = trig_raw ? 1 : 0;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("armed",       int'(armed),       int'(m_phase == PH_WATCH));
            chk("busy",        int'(busy),        int'(m_phase == PH_PULSE || m_phase == PH_DEAD));
            chk("trig_valid",  int'(trig_valid),  int'(m_valid));
            chk("event_cnt",   int'(event_cnt),   m_cnt);
            chk("pulse_width", int'(pulse_width), m_pw);
            chk("overflow",    int'(overflow),    int'(m_ovf));
        end
    end

    // Drive trig_raw high for hi sampled cycles then low for lo; record the
    // first negedge index (1 = after first edge) showing trig_valid.
    task automatic run_pulse(input int hi, input int lo, output int first_tv, output int n_tv);
        first_tv = -1;
        n_tv     = 0;
        trig_raw = 1'b1;
        for (int i = 1; i <= hi + lo; i++) begin
            @(negedge clk);
            if (i == hi) trig_raw = 1'b0;
            if (trig_valid) begin
                n_tv++;
                if (first_tv < 0) first_tv = i;
            end
        end
    endtask

    initial begin
        int f, n, tot;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_armed", int'(armed), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tv", int'(trig_valid), 0);
        chk("rst_cnt", int'(event_cnt), 0);
        chk("rst_pw", int'(pulse_width), 0);
        chk("rst_ovf", int'(overflow), 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Qualified 10-cycle pulse with a 4-sample filter.
        ena = 1'b1; filt_len = 4'd4; holdoff_len = 8'd0; arm = 1'b1;
        repeat (2) @(negedge clk);
        chk("armed_after_arm", int'(armed), 1);
        run_pulse(10, 8, f, n);
        chk("lat_filt4", f, 6);
        chk("ntv_long", n, 1);
        chk("cnt_long", int'(event_cnt), 1);
        chk("pw_long", int'(pulse_width), 10);

        // Glitch shorter than the filter is rejected.
        run_pulse(3, 6, f, n);
        chk("ntv_glitch", n, 0);
        chk("cnt_glitch", int'(event_cnt), 1);
        chk("armed_glitch", int'(armed), 1);
        chk("pw_glitch", int'(pulse_width), 10);

        // Hold-off: pulse inside dead time ignored, later pulse counted.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("cnt_cleared", int'(event_cnt), 0);
        chk("pw_cleared", int'(pulse_width), 0);
        filt_len = 4'd2; holdoff_len = 8'd5;
        run_pulse(4, 2, f, n);
        chk("ntv_hold1", n, 1);
        chk("lat_filt2", f, 4);
        run_pulse(2, 10, f, n);
        chk("ntv_hold2", n, 0);
        run_pulse(3, 10, f, n);
        chk("ntv_hold3", n, 1);
        chk("cnt_hold", int'(event_cnt), 2);
        chk("pw_hold", int'(pulse_width), 3);

        // Tile enable low parks the sequencer.
        ena = 1'b0;
        @(negedge clk);
        chk("ena_off_armed", int'(armed), 0);
        chk("ena_off_cnt", int'(event_cnt), 2);
        ena = 1'b1;
        repeat (2) @(negedge clk);
        chk("ena_on_armed", int'(armed), 1);

        // Saturation and overflow with filt_len=0 (acts as 1).
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        filt_len = 4'd0; holdoff_len = 8'd0;
        tot = 0;
        for (int k = 0; k < 256; k++) begin
            run_pulse(1, 5, f, n);
            if (k == 0) chk("lat_filt0", f, 3);
            tot += n;
        end
        chk("ntv_sat", tot, 256);
        chk("cnt_sat", int'(event_cnt), 255);
        chk("ovf_sat", int'(overflow), 1);

        // clear in the same cycle as a trigger wins.
        trig_raw = 1'b1;
        @(negedge clk);
        trig_raw = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_tv", int'(trig_valid), 1);
        chk("clr_cnt", int'(event_cnt), 0);
        chk("clr_ovf", int'(overflow), 0);
        repeat (4) @(negedge clk);

        // 300-cycle pulse saturates width; arm dropped mid-pulse is ignored.
        filt_len = 4'd1; holdoff_len = 8'd3;
        trig_raw = 1'b1;
        repeat (50) @(negedge clk);
        chk("long_busy", int'(busy), 1);
        arm = 1'b0;
        repeat (250) @(negedge clk);
        chk("long_busy_noarm", int'(busy), 1);
        trig_raw = 1'b0;
        repeat (12) @(negedge clk);
        chk("pw_sat", int'(pulse_width), 255);
        chk("long_cnt", int'(event_cnt), 1);
        chk("long_idle_armed", int'(armed), 0);
        chk("long_idle_busy", int'(busy), 0);

        // Asynchronous reset in the middle of ACTIVE.
        arm = 1'b1;
        repeat (2) @(negedge clk);
        trig_raw = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_cnt", int'(event_cnt), 0);
        chk("arst_pw", int'(pulse_width), 0);
        chk("arst_armed", int'(armed), 0);
        trig_raw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_armed", int'(armed), 1);
        chk("post_rst_busy", int'(busy), 0);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
